shift_right_8bit_seq: RTL
=========================

# shift_right_8bit_seq

Sequential 8-bit right-shift unit for the 8-bit ALU datapath, the right-direction counterpart of the combinational left barrel shifter. It shifts one bit position per clock under a small FSM and supports logical, arithmetic and rotate modes. It uses a start/busy/done handshake and reports the last bit shifted out. It sits beside the left shifter in the ALU result mux and trades latency for area: one 8-bit stage instead of three.

## Interface
Parameters:
- none; width is fixed at 8 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  8  operand to shift
- b  input  8  shift amount; only b[2:0] is used, b[7:3] is ignored
- mode  input  2  shift mode: 00 logical, 01 arithmetic, 10 rotate right, 11 reserved (behaves as 00)
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse; y and carry_out are valid in that cycle
- y  output  8  result register
- carry_out  output  1  last bit shifted or rotated out of bit 0

## Operation
- FSM states are IDLE, SHIFT and DONE.
- IDLE with start=1:
  - load the data register with a, cnt with b[2:0], and latch mode; clear carry_out.
  - next state is SHIFT if cnt≠0, else DONE.
- IDLE with start=0: hold all registers.
- SHIFT, each cycle:
  - carry_out ← reg[0]; reg[6:0] ← reg[7:1]; cnt ← cnt−1.
  - reg[7] ← 0 (logical), reg[7] (arithmetic), or old reg[0] (rotate).
  - when cnt reaches 0 → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- y is driven directly from the data register.
  - y is not guaranteed meaningful during SHIFT.
  - y and carry_out hold their final values after DONE until the next accepted start.
- start is ignored while busy=1, including the DONE cycle; no queuing.
- mode and b are latched at start; changes during SHIFT have no effect.
- Asynchronous reset at any time, including mid-shift: state=IDLE; y, carry_out, cnt and the latched mode all go to 0; busy=0 and done=0. The operation in flight is discarded with no done pulse.

## Timing
- start is sampled at edge T with amount N=b[2:0]. busy goes high after T, and done is high during cycle T+N+1.
- Latency: N=0 → done in cycle T+1; N=7 → done in cycle T+8.
- busy falls after the DONE cycle. The earliest next accepted start is at edge T+N+2, so the minimum start-to-start spacing is N+2 cycles.
- Reset values: busy=0, done=0, y=8'h00, carry_out=0.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared ALU package holds:
  - the mode encodings (SHR_LOGIC=2'b00, SHR_ARITH=2'b01, SHR_ROTATE=2'b10);
  - the FSM state typedef (IDLE, SHIFT, DONE);
  - the 8-bit data width constant.
- Sub-module: the existing mux2 forms the one-bit shift stage.
  - one mux2 per bit selects hold vs shifted value;
  - one extra mux2 selects the fill bit for reg[7] by mode.
- The FSM, counter and carry logic live in the top module.
- Target size is roughly 150–250 lines.

## Test plan
- Logical: a=8'hB4, b=3, mode=00 → y=8'h16, carry_out=1, done 4 cycles after the start edge.
- Arithmetic: a=8'hB4, b=3, mode=01 → y=8'hF6, carry_out=1; and a=8'h74, b=2 → y=8'h1D, carry_out=0.
- Rotate: a=8'h81, b=1, mode=10 → y=8'hC0, carry_out=1; and a=8'h0F, b=4 → y=8'hF0, carry_out=1.
- Zero amount from an ignored upper field: a=8'h5A, b=8'h08 → y=8'h5A, carry_out=0, done in cycle T+1. Also a=8'h80, b=7, mode=00 → y=8'h01, carry_out=0, done in T+8.
- Handshake:
  - start pulsed during SHIFT and during DONE → ignored; exactly one done pulse and the result is unchanged.
  - a start at edge T+N+2 is accepted.
  - mode=11 gives the same result as mode=00.
- Reset mid-shift: assert rst_n=0 asynchronously two cycles into b=6 → y=0, carry_out=0 and busy=0 immediately, with no done pulse. After release, a new start completes normally.

Source files
------------

// File: rtl/shift_right_8bit_seq_pkg.sv
// Shared definitions for the sequential right shifter: data width,
// shift-mode encodings and FSM state type.
package shift_right_8bit_seq_pkg;

  localparam int DATA_W = 8;
  // Counter width covers shift amounts 0..7 (b[2:0]).
  localparam int CNT_W  = 3;

  localparam logic [1:0] SHR_LOGIC  = 2'b00;
  localparam logic [1:0] SHR_ARITH  = 2'b01;
  localparam logic [1:0] SHR_ROTATE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shr_state_e;

endpackage

// File: rtl/mux2.sv
// One-bit 2:1 multiplexer; used as the per-bit stage of the shifter.
module mux2 (
  input  logic i_d0,
  input  logic i_d1,
  input  logic i_sel,
  output logic o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/shift_right_8bit_seq.sv
// Sequential 8-bit right shifter: one bit position per clock, logical,
// arithmetic or rotate, with a start/busy/done handshake and carry-out.
module shift_right_8bit_seq
  import shift_right_8bit_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] y,
  output logic              carry_out
);

  shr_state_e        r_state;
  shr_state_e        w_next_state;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_mode;
  logic              r_carry;

  logic              w_accept;
  logic              w_shift_en;
  logic              w_is_arith;
  logic              w_rot_bit;
  logic              w_fill;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_stage;
  logic              w_unused_b;

  // Upper shift-amount bits carry no meaning for an 8-bit operand.
  assign w_unused_b = ^b[DATA_W-1:CNT_W];

  assign w_accept   = (r_state == IDLE) && start;
  assign w_shift_en = (r_state == SHIFT);

  // Fill bit for reg[7]: old MSB when arithmetic, old LSB when rotating,
  // zero otherwise (logical and the reserved encoding).
  assign w_is_arith = (r_mode == SHR_ARITH);
  assign w_rot_bit  = (r_mode == SHR_ROTATE) & r_data[0];

  mux2 u_fill_mux (
    .i_d0  (w_rot_bit),
    .i_d1  (r_data[DATA_W-1]),
    .i_sel (w_is_arith),
    .o_y   (w_fill)
  );

  assign w_shifted = {w_fill, r_data[DATA_W-1:1]};

  // Per-bit stage: hold the register value, or take the shifted value in SHIFT.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_stage
    mux2 u_bit_mux (
      .i_d0  (r_data[gi]),
      .i_d1  (w_shifted[gi]),
      .i_sel (w_shift_en),
      .o_y   (w_stage[gi])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode; a zero amount skips SHIFT and goes straight to DONE.
  always_comb begin
    // NOTE: default first so no path leaves w_next_state unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = (b[CNT_W-1:0] != '0) ? SHIFT : DONE;
      SHIFT:   if (r_cnt == CNT_W'(1)) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: load operand/amount/mode on an accepted start, then shift
  // one bit per SHIFT cycle, capturing the bit leaving position 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_cnt   <= '0;
      r_mode  <= SHR_LOGIC;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_data  <= a;
      r_cnt   <= b[CNT_W-1:0];
      r_mode  <= mode;
      r_carry <= 1'b0;
    end else begin
      r_data <= w_stage;
      if (w_shift_en) begin
        r_carry <= r_data[0];
        r_cnt   <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign y         = r_data;
  assign carry_out = r_carry;

endmodule
